// File: rtl/msrv32_pkg.sv
// Shared RV32I decode constants: opcodes, immediate-format codes and
// the buffered-entry record used by the decode-stage controller.
package msrv32_pkg;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_I_LD = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;
  localparam logic [2:0] IMM_CSR  = 3'b110;
  localparam logic [2:0] IMM_DEF  = 3'b111;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm_type;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/msrv32_decode_ctrl_if.sv
// Fetch-to-decode bundle: upstream instruction handshake plus the
// buffered instruction presented to the decode stage.
interface msrv32_decode_ctrl_if;

  logic        instr_valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        instr_ready_out;
  logic        dec_valid_out;
  logic        dec_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  imm_type_out;
  logic        illegal_out;

  modport master (
    output instr_valid_in, instr_in, pc_in, dec_ready_in,
    input  instr_ready_out, dec_valid_out, instr_out, pc_out,
           imm_type_out, illegal_out
  );

  modport slave (
    input  instr_valid_in, instr_in, pc_in, dec_ready_in,
    output instr_ready_out, dec_valid_out, instr_out, pc_out,
           imm_type_out, illegal_out
  );

endinterface

// File: rtl/msrv32_opcode_classify.sv
// Combinational opcode classifier: immediate format and RV32I legality.
module msrv32_opcode_classify
  import msrv32_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output logic       illegal
);

  always_comb begin
    imm_type = IMM_DEF;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP_IMM:         imm_type = IMM_I;
      OPC_LOAD, OPC_JALR: imm_type = IMM_I_LD;
      OPC_STORE:          imm_type = IMM_S;
      OPC_BRANCH:         imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
      OPC_JAL:            imm_type = IMM_J;
      // Only the immediate CSR forms carry a zimm operand
      OPC_SYSTEM:         imm_type = funct3[2] ? IMM_CSR : IMM_DEF;
      OPC_OP, OPC_MISC_MEM: imm_type = IMM_DEF;
      default:            illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/msrv32_decode_ctrl.sv
// Decode-stage controller: 2-entry skid buffer between fetch and decode,
// with opcode classification stored per entry.
module msrv32_decode_ctrl
  import msrv32_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic flush_in,
  msrv32_decode_ctrl_if.slave bus
);

  localparam entry_t RESET_ENTRY = '{instr: RESET_INSTR, pc: RESET_PC,
                                     imm_type: IMM_I, illegal: 1'b0};

  occ_state_t state, next_state;
  entry_t     out_q, out_d, skid_q, skid_d, in_entry;
  logic [2:0] in_imm_type;
  logic       in_illegal;
  logic       in_fire, out_fire;

  msrv32_opcode_classify u_classify (
    .funct3   (bus.instr_in[14:12]),
    .opcode   (bus.instr_in[6:0]),
    .imm_type (in_imm_type),
    .illegal  (in_illegal)
  );

  assign in_entry = '{instr: bus.instr_in, pc: bus.pc_in,
                      imm_type: in_imm_type, illegal: in_illegal};

  // Ready depends only on registered occupancy, never on dec_ready_in
  assign bus.instr_ready_out = (state != OCC_FULL);
  assign bus.dec_valid_out   = (state != OCC_EMPTY);
  assign bus.instr_out       = out_q.instr;
  assign bus.pc_out          = out_q.pc;
  assign bus.imm_type_out    = out_q.imm_type;
  assign bus.illegal_out     = out_q.illegal;

  assign in_fire  = bus.instr_valid_in & bus.instr_ready_out;
  assign out_fire = bus.dec_valid_out & bus.dec_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= OCC_EMPTY;
      out_q  <= RESET_ENTRY;
      skid_q <= RESET_ENTRY;
    end else begin
      state  <= next_state;
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    next_state = state;
    out_d      = out_q;
    skid_d     = skid_q;
    if (flush_in) begin
      next_state = OCC_EMPTY;
      out_d      = RESET_ENTRY;
      skid_d     = RESET_ENTRY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_fire) begin
            out_d      = in_entry;
            next_state = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            out_d = in_entry;
          end else if (in_fire) begin
            skid_d     = in_entry;
            next_state = OCC_FULL;
          end else if (out_fire) begin
            next_state = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // Skid entry is always the younger one, so it moves up in order
          if (out_fire) begin
            out_d      = skid_q;
            skid_d     = RESET_ENTRY;
            next_state = OCC_ONE;
          end
        end
        default: next_state = OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_decode_ctrl.sv
// Scoreboard bench for msrv32_decode_ctrl: accepted instructions are queued
// with their expected classification and compared when decode consumes them.
module tb_msrv32_decode_ctrl;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  imm_type;
    logic        illegal;
  } sb_item_t;

  logic clk;
  logic rst;
  logic flush;

  msrv32_decode_ctrl_if bus ();

  msrv32_decode_ctrl #(
    .RESET_INSTR (32'h0000_0013),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .flush_in (flush),
    .bus      (bus.slave)
  );

  sb_item_t sb[$];
  int       vector_count;
  int       miscompare_count;
  bit       at_reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_instr"}, bus.instr_out, 32'h0000_0013);
    checkOutput({tag, "_pc"}, bus.pc_out, 32'h0000_0000);
    checkOutput({tag, "_imm"}, {29'b0, bus.imm_type_out}, 32'd0);
    checkOutput({tag, "_illegal"}, {31'b0, bus.illegal_out}, 32'd0);
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [2:0] imm,
                               input logic ill, input logic ready,
                               input logic flush_now);
    sb_item_t head;
    bit       exp_valid, exp_ready, out_fire, in_fire;
    bus.instr_valid_in = valid;
    bus.instr_in       = instr;
    bus.pc_in          = pc;
    bus.dec_ready_in   = ready;
    flush              = flush_now;
    @(negedge clk);
    exp_valid = (sb.size() > 0);
    exp_ready = (sb.size() < 2);
    checkOutput("dec_valid", {31'b0, bus.dec_valid_out}, {31'b0, exp_valid});
    checkOutput("instr_ready", {31'b0, bus.instr_ready_out}, {31'b0, exp_ready});
    if (exp_valid) begin
      head = sb[0];
      checkOutput("instr", bus.instr_out, head.instr);
      checkOutput("pc", bus.pc_out, head.pc);
      checkOutput("imm_type", {29'b0, bus.imm_type_out}, {29'b0, head.imm_type});
      checkOutput("illegal", {31'b0, bus.illegal_out}, {31'b0, head.illegal});
    end else if (at_reset) begin
      checkResetValues("idle");
    end
    out_fire = exp_valid && ready;
    in_fire  = valid && exp_ready;
    if (flush_now) begin
      sb.delete();
      at_reset = 1'b1;
    end else begin
      if (out_fire) head = sb.pop_front();
      if (in_fire) begin
        sb.push_back('{instr: instr, pc: pc, imm_type: imm, illegal: ill});
        at_reset = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ready, input int cycles);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vector_count       = 0;
    miscompare_count   = 0;
    at_reset           = 1'b1;
    rst                = 1'b1;
    flush              = 1'b0;
    bus.instr_valid_in = 1'b0;
    bus.instr_in       = 32'h0;
    bus.pc_in          = 32'h0;
    bus.dec_ready_in   = 1'b0;

    #2;
    checkOutput("rst_valid", {31'b0, bus.dec_valid_out}, 32'd0);
    checkResetValues("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single ADDI, then the buffer drains
    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0100, 3'b000, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Back-pressure: fill both entries, third push must be refused
    applyStimulus(1'b1, 32'h0020_A223, 32'h0000_0104, 3'b010, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0020_8463, 32'h0000_0108, 3'b011, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_010C, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_010C, 3'b000, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Streaming with valid and ready held high
    applyStimulus(1'b1, 32'h1234_50B7, 32'h0000_0200, 3'b100, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0080_00EF, 32'h0000_0204, 3'b101, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h3400_D073, 32'h0000_0208, 3'b110, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h3401_1073, 32'h0000_020C, 3'b111, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_A103, 32'h0000_0210, 3'b001, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_80E7, 32'h0000_0214, 3'b001, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_1117, 32'h0000_0218, 3'b100, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0073, 32'h0000_021C, 3'b111, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_000F, 32'h0000_0220, 3'b111, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Illegal encodings versus legal register-register OP
    applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0300, 3'b111, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0020_81B3, 32'h0000_0304, 3'b111, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0308, 3'b111, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Flush while full with a simultaneous valid instruction
    applyStimulus(1'b1, 32'h0020_A223, 32'h0000_0400, 3'b010, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0020_8463, 32'h0000_0404, 3'b011, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1234_50B7, 32'h0000_0408, 3'b100, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Flush coinciding with a downstream consume
    applyStimulus(1'b1, 32'h0050_0093, 32'h0000_0500, 3'b000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0080_00EF, 32'h0000_0504, 3'b101, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Asynchronous reset in the middle of a cycle while holding one entry
    applyStimulus(1'b1, 32'h0000_A103, 32'h0000_0600, 3'b001, 1'b0, 1'b0, 1'b0);
    bus.instr_valid_in = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_valid", {31'b0, bus.dec_valid_out}, 32'd0);
    checkResetValues("async");
    sb.delete();
    at_reset = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(1'b1, 1);
    applyStimulus(1'b1, 32'h0020_A223, 32'h0000_0700, 3'b010, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vector_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/msrv32_decode_ctrl.md
Name: msrv32_decode_ctrl

Overview:
Decode-stage controller between instruction memory and the immediate generator / decoder. It captures fetched instructions with a valid/ready handshake and buffers them in a 2-entry skid (output register plus skid register). It classifies each opcode into the 3-bit imm_type code the immediate generator consumes, and presents instruction, PC, imm_type and an illegal flag to the decode stage. Supports downstream back-pressure and pipeline flush.

Parameters:
RESET_INSTR, 32'h0000_0013, instruction value presented on instr_out after reset or flush (NOP, addi x0,x0,0).
RESET_PC, 32'h0000_0000, value of pc_out after reset or flush.

Ports:
clk_in  input  1  single clock; all state updates on rising edge.
rst_in  input  1  asynchronous, active-high reset.
flush_in  input  1  synchronous flush (branch/trap redirect); empties the buffer.
instr_valid_in  input  1  upstream instruction valid.
instr_in  input  32  fetched instruction word.
pc_in  input  32  PC of instr_in.
instr_ready_out  output  1  upstream may transfer this cycle.
dec_valid_out  output  1  output entry holds a valid instruction.
dec_ready_in  input  1  decode stage accepts this cycle.
instr_out  output  32  buffered instruction; bits [31:7] feed the immediate generator.
pc_out  output  32  PC of instr_out.
imm_type_out  output  3  immediate format code for instr_out.
illegal_out  output  1  instr_out opcode is not RV32I; qualified by dec_valid_out.

Behaviour:
- Reset (async, rst_in=1): both entries invalid. dec_valid_out=0, instr_ready_out=1 once reset deasserts, instr_out=RESET_INSTR, pc_out=RESET_PC, imm_type_out=3'b000, illegal_out=0.
- Transfers: in_fire = instr_valid_in & instr_ready_out. out_fire = dec_valid_out & dec_ready_in.
- instr_ready_out is driven only from registered state: instr_ready_out = !skid_valid. It is never combinationally dependent on dec_ready_in.
- Occupancy states and transitions:
  - EMPTY (out invalid, skid invalid): on in_fire, load the out entry and go to ONE. Latency is 1 cycle from in_fire to dec_valid_out.
  - ONE (out valid, skid invalid):
    - in_fire & out_fire: replace the out entry and stay in ONE.
    - in_fire & !out_fire: load the skid entry and go to FULL.
    - !in_fire & out_fire: go to EMPTY.
  - FULL (both valid, instr_ready_out=0): on out_fire, move skid to out, clear skid, go to ONE. No input is accepted while FULL.
- Ordering: strict FIFO. The skid entry is always younger than the out entry.
- imm_type is decoded from opcode instr[6:0] on load and registered alongside the entry (stored per entry, not decoded at the output):
  - 0010011 OP-IMM -> 000
  - 0000011 LOAD and 1100111 JALR -> 001
  - 0100011 STORE -> 010
  - 1100011 BRANCH -> 011
  - 0110111 LUI and 0010111 AUIPC -> 100
  - 1101111 JAL -> 101
  - 1110011 SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) -> 110
  - all others (OP, MISC-MEM, SYSTEM with funct3[2]=0, illegal) -> 111
- illegal = opcode not in {OP-IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM, OP 0110011, MISC-MEM 0001111}. Registered per entry.
- flush_in:
  - Has priority over every transfer in the same cycle.
  - Next state is EMPTY; outputs return to their reset values except instr_ready_out=1.
  - A same-cycle in_fire is discarded. A same-cycle out_fire still counts as consumed by the downstream stage.
- rst_in asserted mid-transfer: state clears immediately (asynchronous). No partial entry survives.
- instr_out/pc_out hold stable while dec_valid_out=1 and dec_ready_in=0. Standard valid/ready hold rule: dec_valid_out is never deasserted without out_fire or flush.

Decomposition:
- Shared package msrv32_pkg:
  - opcode localparams (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_OP, OPC_MISC_MEM);
  - imm_type codes IMM_I=3'b000, IMM_I_LD=3'b001, IMM_S=3'b010, IMM_B=3'b011, IMM_U=3'b100, IMM_J=3'b101, IMM_CSR=3'b110, IMM_DEF=3'b111.
- One sub-module: msrv32_opcode_classify. Purely combinational, maps instr[14:12], instr[6:0] to {imm_type, illegal}. Instantiated once on instr_in; its result is stored per entry.

Test Plan:
- Reset then single ADDI 32'h0050_0093 with dec_ready_in=1 -> next cycle dec_valid_out=1, imm_type_out=000, illegal_out=0; following cycle dec_valid_out=0. During reset instr_out=32'h0000_0013.
- Back-pressure: dec_ready_in=0, push SW 32'h0020_A223 then BEQ 32'h0020_8463 -> after 2nd push instr_ready_out=0, and a 3rd valid is not accepted. Release dec_ready_in -> SW (010) emitted, then BEQ (011), in order.
- Streaming with valid and ready held high: LUI, JAL, CSRRWI 32'h3400_D073, CSRRW 32'h3401_1073 -> imm_type_out sequence 100, 101, 110, 111 on consecutive cycles, zero bubbles, instr_ready_out constantly 1.
- Illegal: instr_in=32'h0000_0000 -> illegal_out=1, imm_type_out=111. Opcode 0110011 (ADD) -> illegal_out=0, imm_type_out=111.
- Flush while FULL with simultaneous instr_valid_in=1 -> next cycle dec_valid_out=0, instr_ready_out=1, pc_out=0, and the flushed-cycle instruction never appears at the output.
- Async reset pulsed mid-cycle while ONE with dec_ready_in=0 -> dec_valid_out falls without a clock edge; post-reset values are as specified.
